// File: rtl/telemetry_pkg.sv
// Shared constants and types for the eBike telemetry receiver.
package telemetry_pkg;

    localparam logic [7:0]  HDR1      = 8'hAA;
    localparam logic [7:0]  HDR2      = 8'h55;
    localparam int unsigned PAY_BYTES = 6;

    typedef enum logic [1:0] {PKT_HDR1, PKT_HDR2, PKT_PAY} pkt_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef struct packed {
        logic [11:0] batt;
        logic [11:0] curr;
        logic [11:0] torque;
    } telem_t;

    // Payload bytes held until the packet completes; torque low byte goes straight to the outputs.
    typedef struct packed {
        logic [11:0] batt;
        logic [11:0] curr;
        logic [3:0]  torque_hi;
    } shadow_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: synchroniser, start-bit validation, centre sampling.
module uart_rx
    import telemetry_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    rx_state_t     r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync_q;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_q <= 1'b1;
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bitn   <= '0;
            r_shift  <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            r_sync1  <= RX;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2 && r_sync_q) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            rx_data <= r_shift;
                            rdy     <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: header lock, payload reassembly, atomic output update.
module telemetry_rx
    import telemetry_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned TMO_CYC  = 20 * BAUD_DIV,
    parameter int unsigned FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        pkt_err
);

    localparam int unsigned BD  = (FAST_SIM != 0) ? 16  : BAUD_DIV;
    localparam int unsigned TMO = (FAST_SIM != 0) ? 320 : TMO_CYC;
    localparam int unsigned TW  = $clog2(TMO + 1);

    logic [7:0] w_rx_data;
    logic       w_rdy;
    logic       w_frm_err;

    pkt_state_t r_state;
    logic [2:0] r_idx;
    shadow_t    r_shd;
    telem_t     r_out;
    logic [TW-1:0] r_tmo;
    logic       r_vld;
    logic       r_pkt_err;

    uart_rx #(
        .BAUD_DIV (BD)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (w_rx_data),
        .rdy     (w_rdy),
        .frm_err (w_frm_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PKT_HDR1;
            r_idx     <= '0;
            r_shd     <= '0;
            r_out     <= '0;
            r_tmo     <= '0;
            r_vld     <= 1'b0;
            r_pkt_err <= 1'b0;
        end else begin
            r_vld     <= 1'b0;
            r_pkt_err <= 1'b0;
            if (w_rdy) begin
                r_tmo <= '0;
                case (r_state)
                    PKT_HDR1: begin
                        if (w_rx_data == HDR1) r_state <= PKT_HDR2;
                    end
                    PKT_HDR2: begin
                        r_idx <= '0;
                        if (w_rx_data == HDR2)      r_state <= PKT_PAY;
                        else if (w_rx_data != HDR1) r_state <= PKT_HDR1;
                    end
                    PKT_PAY: begin
                        // High bytes carry only 4 significant bits.
                        if (!r_idx[0] && (w_rx_data[7:4] != 4'h0)) begin
                            r_pkt_err <= 1'b1;
                            r_state   <= PKT_HDR1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            case (r_idx)
                                3'd0: r_shd.batt[11:8] <= w_rx_data[3:0];
                                3'd1: r_shd.batt[7:0]  <= w_rx_data;
                                3'd2: r_shd.curr[11:8] <= w_rx_data[3:0];
                                3'd3: r_shd.curr[7:0]  <= w_rx_data;
                                3'd4: r_shd.torque_hi  <= w_rx_data[3:0];
                                default: begin
                                    r_out.batt   <= r_shd.batt;
                                    r_out.curr   <= r_shd.curr;
                                    r_out.torque <= {r_shd.torque_hi, w_rx_data};
                                    r_vld        <= 1'b1;
                                    r_state      <= PKT_HDR1;
                                end
                            endcase
                        end
                    end
                    default: r_state <= PKT_HDR1;
                endcase
            end else if (w_frm_err) begin
                r_tmo     <= '0;
                r_pkt_err <= (r_state == PKT_PAY);
                r_state   <= PKT_HDR1;
            end else if (r_state == PKT_HDR1) begin
                r_tmo <= '0;
            end else if (r_tmo == TW'(TMO)) begin
                r_tmo     <= '0;
                r_pkt_err <= (r_state == PKT_PAY);
                r_state   <= PKT_HDR1;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign batt    = r_out.batt;
    assign curr    = r_out.curr;
    assign torque  = r_out.torque;
    assign vld     = r_vld;
    assign pkt_err = r_pkt_err;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx in FAST_SIM mode (16 clocks per bit).
module tb_telemetry_rx;

    localparam int unsigned BIT = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX    = 1'b1;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        vld;
    logic        pkt_err;

    int n_vec    = 0;
    int n_err    = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int v0;
    int e0;

    always #5 clk = ~clk;

    telemetry_rx #(
        .FAST_SIM (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .batt    (batt),
        .curr    (curr),
        .torque  (torque),
        .vld     (vld),
        .pkt_err (pkt_err)
    );

    always @(negedge clk) begin
        if (vld)            vld_cnt++;
        if (pkt_err)        err_cnt++;
        if (vld && pkt_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [11:0] b, input logic [11:0] c,
                             input logic [11:0] t);
        check({tag, "_batt"},   32'(batt),   32'(b));
        check({tag, "_curr"},   32'(curr),   32'(c));
        check({tag, "_torque"}, 32'(torque), 32'(t));
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_payload(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte({4'h0, b[11:8]}, 1'b1);
        send_byte(b[7:0], 1'b1);
        send_byte({4'h0, c[11:8]}, 1'b1);
        send_byte(c[7:0], 1'b1);
        send_byte({4'h0, t[11:8]}, 1'b1);
        send_byte(t[7:0], 1'b1);
    endtask

    task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_payload(b, c, t);
    endtask

    initial begin
        logic [7:0] pb;

        repeat (3) @(negedge clk);
        check_out("reset", 12'h000, 12'h000, 12'h000);
        check("reset_vld",     32'(vld),     32'd0);
        check("reset_pkt_err", 32'(pkt_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean packet.
        v0 = vld_cnt; e0 = err_cnt;
        send_pkt(12'hA5C, 12'h123, 12'h7FF);
        repeat (4) @(negedge clk);
        check("clean_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("clean_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_out("clean", 12'hA5C, 12'h123, 12'h7FF);

        // Junk bytes and a repeated AA before the real header.
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'h13, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_payload(12'h321, 12'hBCD, 12'hF00);
        repeat (4) @(negedge clk);
        check("junk_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check("junk_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_out("junk", 12'h321, 12'hBCD, 12'hF00);

        // Format error on the first high byte.
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h1A, 1'b1);
        repeat (4) @(negedge clk);
        check("fmt_err_cnt", 32'(err_cnt - e0), 32'd1);
        send_byte(8'h5C, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("fmt_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        check_out("fmt_hold", 12'h321, 12'hBCD, 12'hF00);
        v0 = vld_cnt;
        send_pkt(12'hA5C, 12'h123, 12'h7FF);
        repeat (4) @(negedge clk);
        check("fmt_next_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check_out("fmt_next", 12'hA5C, 12'h123, 12'h7FF);

        // Framing error (stop bit low) on payload byte 4.
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h22, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h33, 1'b1);
        check("frm_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("frm_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        check_out("frm_hold", 12'hA5C, 12'h123, 12'h7FF);

        // Timeout after the first payload byte.
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        repeat (400) @(negedge clk);
        check("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("tmo_vld_cnt", 32'(vld_cnt - v0), 32'd0);
        v0 = vld_cnt;
        send_pkt(12'h0F0, 12'h00F, 12'h555);
        repeat (4) @(negedge clk);
        check("tmo_next_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check_out("tmo_next", 12'h0F0, 12'h00F, 12'h555);

        // Reset during bit 3 of payload byte 2.
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        pb = 8'h5C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(pb[i]);
        RX = pb[3];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_out("rst_mid", 12'h000, 12'h000, 12'h000);
        check("rst_mid_vld", 32'(vld), 32'd0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_out("rst_after", 12'h000, 12'h000, 12'h000);

        // Two clean packets with no gap between any bytes.
        v0 = vld_cnt; e0 = err_cnt;
        send_pkt(12'hA5C, 12'h123, 12'h7FF);
        check("b2b_first_vld_cnt", 32'(vld_cnt - v0), 32'd1);
        check_out("b2b_first", 12'hA5C, 12'h123, 12'h7FF);
        send_pkt(12'h321, 12'hBCD, 12'hF00);
        repeat (4) @(negedge clk);
        check("b2b_vld_cnt", 32'(vld_cnt - v0), 32'd2);
        check("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_out("b2b_second", 12'h321, 12'hBCD, 12'hF00);

        check("vld_and_err_same_cycle", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
